// File: rtl/mc16_pin_loader.sv
// Pin-level program loader: 4-phase strobe/ack byte intake, 16-bit word assembly and
// ready-handshaked instruction memory writes. Optional checksum view: MC16_LOADER_CHECKSUM_EN.
module mc16_pin_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        host_data,
  input  logic              host_stb,
  input  logic              host_cmd,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              core_run,
  output logic [7:0]        status
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              stb_s1_q, stb_s2_q;
  logic [1:0]        state_q, state_d;
  logic              ack_q, ack_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic              phase_q, phase_d;
  logic [7:0]        lo_q, lo_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy;
`ifdef MC16_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              view_q, view_d;
`endif

  // A data byte that arrives while the core runs is acked but never stored.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    err_d   = err_q;
    phase_d = phase_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
`ifdef MC16_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    view_d  = view_q;
`endif
    case (state_q)
      IDLE: begin
        if (stb_s2_q && ena) begin
          if (host_cmd) begin
            phase_d = 1'b0;
            state_d = ACK;
            ack_d   = 1'b1;
            case (host_data)
              8'h00: begin
                addr_d = '0;
                cnt_d  = 4'd0;
                err_d  = 1'b0;
`ifdef MC16_LOADER_CHECKSUM_EN
                csum_d = 8'h00;
`endif
              end
              8'h01: run_d = 1'b1;
              8'h02: run_d = 1'b0;
`ifdef MC16_LOADER_CHECKSUM_EN
              8'h03: view_d = ~view_q;
`endif
              default: err_d = 1'b1;
            endcase
          end else if (run_q) begin
            err_d   = 1'b1;
            state_d = ACK;
            ack_d   = 1'b1;
          end else if (!phase_q) begin
            lo_d    = host_data;
            phase_d = 1'b1;
            state_d = ACK;
            ack_d   = 1'b1;
`ifdef MC16_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ host_data;
`endif
          end else begin
            wdata_d = {host_data, lo_q};
            phase_d = 1'b0;
            we_d    = 1'b1;
            state_d = WRITE;
`ifdef MC16_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ host_data;
`endif
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          we_d    = 1'b0;
          addr_d  = addr_q + ADDR_ONE;
          cnt_d   = cnt_q + 4'd1;
          state_d = ACK;
        end
      end
      ACK: begin
        // After a write the ack is raised one cycle late, then held until the host drops its strobe.
        if (!ack_q) begin
          ack_d = 1'b1;
        end else if (!stb_s2_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_s1_q <= 1'b0;
      stb_s2_q <= 1'b0;
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      phase_q  <= 1'b0;
      lo_q     <= 8'h00;
      cnt_q    <= 4'd0;
`ifdef MC16_LOADER_CHECKSUM_EN
      csum_q   <= 8'h00;
      view_q   <= 1'b0;
`endif
    end else begin
      stb_s1_q <= host_stb;
      stb_s2_q <= stb_s1_q;
      state_q  <= state_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      run_q    <= run_d;
      err_q    <= err_d;
      phase_q  <= phase_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
`ifdef MC16_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
      view_q   <= view_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign host_ack  = ack_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_run  = run_q;
`ifdef MC16_LOADER_CHECKSUM_EN
  assign status    = view_q ? csum_q : {err_q, run_q, phase_q, busy, cnt_q};
`else
  assign status    = {err_q, run_q, phase_q, busy, cnt_q};
`endif

endmodule

// File: tb/tb_mc16_pin_loader.sv
// Self-checking bench for mc16_pin_loader: transaction-level loader model, write scoreboard,
// handshake latency checks and randomized byte traffic.
module tb_mc16_pin_loader;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [7:0]  host_data;
  logic        host_stb;
  logic        host_cmd;
  logic        host_ack;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        core_run;
  logic [7:0]  status;

  int compared   = 0;
  int mismatched = 0;
  bit checkIdle  = 0;

  // Loader model: programmer-visible state only
  logic [7:0] mAddr;
  logic [3:0] mCnt;
  logic       mErr, mRun, mPhase, mView;
  logic [7:0] mLo, mCsum;
  logic [7:0]  expWrAddr[$];
  logic [15:0] expWrData[$];
  logic [7:0]  lastAddr;
  logic [15:0] lastData;

  mc16_pin_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .host_data(host_data), .host_stb(host_stb), .host_cmd(host_cmd),
    .host_ack(host_ack), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .core_run(core_run), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] expStatus();
`ifdef MC16_LOADER_CHECKSUM_EN
    if (mView) return mCsum;
`endif
    return {mErr, mRun, mPhase, 1'b0, mCnt};
  endfunction

  task automatic modelReset();
    mAddr = 8'h00; mCnt = 4'd0; mErr = 1'b0; mRun = 1'b0; mPhase = 1'b0;
    mView = 1'b0; mLo = 8'h00; mCsum = 8'h00;
    expWrAddr.delete();
    expWrData.delete();
  endtask

  task automatic modelApply(input bit isCmd, input logic [7:0] d);
    if (isCmd) begin
      mPhase = 1'b0;
      if (d == 8'h00) begin
        mAddr = 8'h00; mCnt = 4'd0; mErr = 1'b0; mCsum = 8'h00;
      end else if (d == 8'h01) mRun = 1'b1;
      else if (d == 8'h02) mRun = 1'b0;
`ifdef MC16_LOADER_CHECKSUM_EN
      else if (d == 8'h03) mView = !mView;
`endif
      else mErr = 1'b1;
    end else if (mRun) begin
      mErr = 1'b1;
    end else if (!mPhase) begin
      mLo = d; mPhase = 1'b1; mCsum = mCsum ^ d;
    end else begin
      expWrAddr.push_back(mAddr);
      expWrData.push_back({d, mLo});
      mAddr = mAddr + 8'd1;
      mCnt = mCnt + 4'd1;
      mPhase = 1'b0;
      mCsum = mCsum ^ d;
    end
  endtask

  // Quiescent outputs between transactions must match the model.
  always @(negedge clk) begin
    if (checkIdle) begin
      checkOutput("idle_status", status, expStatus());
      checkOutput("idle_addr", mem_addr, mAddr);
      checkOutput("idle_run", core_run, mRun);
      checkOutput("idle_ack", host_ack, 0);
      checkOutput("idle_we", mem_we, 0);
    end
  end

  // Every cycle a write is pending its address/data must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (expWrAddr.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        checkOutput("write_addr", mem_addr, expWrAddr[0]);
        checkOutput("write_data", mem_wdata, expWrData[0]);
        if (mem_ready) begin
          lastAddr = mem_addr;
          lastData = mem_wdata;
          void'(expWrAddr.pop_front());
          void'(expWrData.pop_front());
        end
      end
    end
  end

  task automatic finishTxn();
    int n;
    host_stb = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!host_ack) break;
    end
    checkOutput("ack_fall_latency", n, 3);
    checkOutput("pending_writes", expWrAddr.size(), 0);
    mem_ready = 1'b1;
    checkIdle = 1'b1;
  endtask

  task automatic applyStimulus(input bit isCmd, input logic [7:0] d, input int dly);
    int n, expLat;
    bit willWrite;
    @(posedge clk); #1;
    checkIdle = 1'b0;
    willWrite = !isCmd && !mRun && mPhase;
    expLat = willWrite ? 5 + dly : 3;
    modelApply(isCmd, d);
    host_cmd  = isCmd;
    host_data = d;
    mem_ready = (dly == 0);
    host_stb  = 1'b1;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n >= 3 + dly) mem_ready = 1'b1;
      if (host_ack) break;
    end
    checkOutput("ack_rise_latency", n, expLat);
    finishTxn();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; host_data = 8'h00; host_stb = 1'b0; host_cmd = 1'b0;
    mem_ready = 1'b1; lastAddr = 8'h00; lastData = 16'h0000;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack", host_ack, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_run", core_run, 0);
    checkOutput("rst_status", status, 8'h00);
    rst_n = 1'b1;
    checkIdle = 1'b1;
    repeat (2) @(posedge clk);

    // Basic word assembly
    applyStimulus(0, 8'h34, 0);
    applyStimulus(0, 8'h12, 0);
    checkOutput("t1_write_addr", lastAddr, 8'h00);
    checkOutput("t1_write_data", lastData, 16'h1234);
    checkOutput("t1_addr_after", mem_addr, 8'h01);
    checkOutput("t1_status", status, 8'h01);

    // Stalled write: ack appears 5 cycles later than with ready tied high
    applyStimulus(0, 8'h56, 0);
    applyStimulus(0, 8'h78, 5);
    checkOutput("t2_write_data", lastData, 16'h7856);

    // Command abandons a partial word
    applyStimulus(0, 8'hAA, 0);
    applyStimulus(1, 8'h00, 0);
    applyStimulus(0, 8'h01, 0);
    applyStimulus(0, 8'h02, 1);
    checkOutput("t4_write_addr", lastAddr, 8'h00);
    checkOutput("t4_write_data", lastData, 16'h0201);

    // Data while running is discarded with error
    applyStimulus(1, 8'h01, 0);
    applyStimulus(0, 8'h55, 0);
    checkOutput("t5_run", core_run, 1);
    checkOutput("t5_err", status[7], 1);
    applyStimulus(1, 8'h02, 0);
    checkOutput("t5_halt", core_run, 0);
    checkOutput("t5_err_sticky", status[7], 1);
    applyStimulus(1, 8'h00, 0);
    checkOutput("t5_err_clear", status[7], 0);

    // ena low blocks the accept only
    @(posedge clk); #1;
    checkIdle = 1'b0;
    ena = 1'b0;
    modelApply(1, 8'h07);
    host_cmd = 1'b1; host_data = 8'h07; host_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("ena_blocked_ack", host_ack, 0);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    checkOutput("ena_ack_rise", host_ack, 1);
    finishTxn();
    checkOutput("unknown_cmd_err", status[7], 1);

    // Full address space wrap
    applyStimulus(1, 8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 8'($urandom), 0);
      applyStimulus(0, 8'($urandom), 0);
    end
    checkOutput("wrap_last_addr", lastAddr, 8'hFF);
    checkOutput("wrap_addr", mem_addr, 8'h00);
    checkOutput("wrap_cnt", status[3:0], 0);
    checkOutput("wrap_err", status[7], 0);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      bit isCmd;
      logic [7:0] d;
      isCmd = ($urandom_range(0, 3) == 0);
      if (isCmd) d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      else d = 8'($urandom);
      applyStimulus(isCmd, d, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a write
    applyStimulus(1, 8'h02, 0);
    applyStimulus(0, 8'h11, 0);
    @(posedge clk); #1;
    checkIdle = 1'b0;
    modelApply(0, 8'h22);
    host_cmd = 1'b0; host_data = 8'h22; mem_ready = 1'b0; host_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_we) break;
    end
    checkOutput("mid_write_we", mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_we", mem_we, 0);
    checkOutput("mid_rst_ack", host_ack, 0);
    checkOutput("mid_rst_addr", mem_addr, 0);
    checkOutput("mid_rst_wdata", mem_wdata, 0);
    checkOutput("mid_rst_run", core_run, 0);
    checkOutput("mid_rst_status", status, 8'h00);
    host_stb = 1'b0;
    mem_ready = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkIdle = 1'b1;
    applyStimulus(0, 8'hCD, 0);
    applyStimulus(0, 8'hAB, 0);
    checkOutput("post_rst_write", lastData, 16'hABCD);
    checkOutput("post_rst_addr", lastAddr, 8'h00);

    @(posedge clk);
    checkIdle = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
